// File: rtl/clkdiv_burst_if.sv
// Request/status bundle between a serial-bus engine and the clkdiv_burst generator.
// The engine drives the master side; the divider implements the slave side.
interface clkdiv_burst_if #(
    parameter int DIV_WIDTH   = 8,
    parameter int COUNT_WIDTH = 8
);
    logic                   start;
    logic [DIV_WIDTH-1:0]   div;
    logic                   cpol;
    logic [COUNT_WIDTH-1:0] npulses;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   div_clk;
    logic                   lead;
    logic                   trail;

    modport master (
        output start, div, cpol, npulses, abort,
        input  busy, done, div_clk, lead, trail
    );

    modport slave (
        input  start, div, cpol, npulses, abort,
        output busy, done, div_clk, lead, trail
    );
endinterface

// File: rtl/clkdiv_burst.sv
// Burst clock divider: emits N glitch-free pulses of period D with lead/trail strobes and a done pulse.
// Optional early termination is built when CLKDIV_BURST_ABORT_EN is defined.
module clkdiv_burst #(
    parameter int DIV_WIDTH   = 8,
    parameter int COUNT_WIDTH = 8,
    parameter bit RESET_CPOL  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    clkdiv_burst_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE       = 3'b001,
        ST_RUN        = 3'b010,
        ST_ABORT_WAIT = 3'b100
    } state_t;

    state_t                 state_r, state_s;
    logic [DIV_WIDTH-1:0]   phase_r, phase_s;
    logic [DIV_WIDTH-1:0]   div_r, div_s;
    logic [COUNT_WIDTH-1:0] pcount_r, pcount_s;
    logic [COUNT_WIDTH-1:0] npulses_r, npulses_s;
    logic                   cpol_r, cpol_s;
    logic                   abort_pend_r, abort_pend_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   clk_r, clk_s;
    logic                   lead_r, lead_s;
    logic                   trail_r, trail_s;

    logic [DIV_WIDTH-1:0]   half_s;
    logic [DIV_WIDTH-1:0]   phase_inc_s;
    logic                   wrap_s;
    logic                   abort_exit_s;
    logic                   last_s;

    assign half_s      = {1'b0, div_r[DIV_WIDTH-1:1]};
    assign wrap_s      = (phase_r == (div_r - DIV_WIDTH'(1)));
    assign phase_inc_s = phase_r + DIV_WIDTH'(1);

`ifdef CLKDIV_BURST_ABORT_EN
    // A live abort at the wrap, a remembered one, or ABORT_WAIT all end the burst at this wrap.
    assign abort_exit_s = bus.abort | abort_pend_r | (state_r == ST_ABORT_WAIT);
`else
    logic abort_unused_s;
    assign abort_unused_s = bus.abort;
    assign abort_exit_s   = 1'b0;
`endif

    assign last_s = (pcount_r == npulses_r) | abort_exit_s;

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_s      = state_r;
        phase_s      = phase_r;
        div_s        = div_r;
        pcount_s     = pcount_r;
        npulses_s    = npulses_r;
        cpol_s       = cpol_r;
        abort_pend_s = abort_pend_r;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        clk_s        = cpol_r;
        lead_s       = 1'b0;
        trail_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                clk_s = bus.cpol;
                if (bus.start) begin
                    div_s     = (bus.div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : bus.div;
                    cpol_s    = bus.cpol;
                    npulses_s = bus.npulses;
                    if (bus.npulses != {COUNT_WIDTH{1'b0}}) begin
                        state_s      = ST_RUN;
                        phase_s      = {DIV_WIDTH{1'b0}};
                        pcount_s     = COUNT_WIDTH'(1);
                        abort_pend_s = 1'b0;
                        busy_s       = 1'b1;
                        clk_s        = ~bus.cpol;
                        lead_s       = 1'b1;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef CLKDIV_BURST_ABORT_EN
            ST_RUN, ST_ABORT_WAIT: begin
`else
            ST_RUN: begin
`endif
                busy_s = 1'b1;
                if (wrap_s) begin
                    if (last_s) begin
                        state_s      = ST_IDLE;
                        phase_s      = {DIV_WIDTH{1'b0}};
                        pcount_s     = {COUNT_WIDTH{1'b0}};
                        abort_pend_s = 1'b0;
                        busy_s       = 1'b0;
                        done_s       = 1'b1;
                        clk_s        = cpol_r;
                    end else begin
                        phase_s  = {DIV_WIDTH{1'b0}};
                        pcount_s = pcount_r + COUNT_WIDTH'(1);
                        clk_s    = ~cpol_r;
                        lead_s   = 1'b1;
                    end
                end else begin
                    phase_s = phase_inc_s;
                    clk_s   = (phase_inc_s < half_s) ? ~cpol_r : cpol_r;
                    trail_s = (phase_inc_s == half_s);
`ifdef CLKDIV_BURST_ABORT_EN
                    // Abort in the active half parks in ABORT_WAIT; in the idle half it is remembered.
                    if (bus.abort && (state_r == ST_RUN)) begin
                        if (phase_r < half_s) begin
                            state_s = ST_ABORT_WAIT;
                        end else begin
                            abort_pend_s = 1'b1;
                        end
                    end else begin
                        abort_pend_s = abort_pend_r;
                    end
`endif
                end
            end
            default: begin
                state_s      = ST_IDLE;
                phase_s      = {DIV_WIDTH{1'b0}};
                pcount_s     = {COUNT_WIDTH{1'b0}};
                abort_pend_s = 1'b0;
                clk_s        = cpol_r;
            end
        endcase
    end

    // State, counters, latched burst parameters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            phase_r      <= {DIV_WIDTH{1'b0}};
            div_r        <= {DIV_WIDTH{1'b0}};
            pcount_r     <= {COUNT_WIDTH{1'b0}};
            npulses_r    <= {COUNT_WIDTH{1'b0}};
            cpol_r       <= RESET_CPOL;
            abort_pend_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            clk_r        <= RESET_CPOL;
            lead_r       <= 1'b0;
            trail_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            phase_r      <= phase_s;
            div_r        <= div_s;
            pcount_r     <= pcount_s;
            npulses_r    <= npulses_s;
            cpol_r       <= cpol_s;
            abort_pend_r <= abort_pend_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            clk_r        <= clk_s;
            lead_r       <= lead_s;
            trail_r      <= trail_s;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.div_clk = clk_r;
    assign bus.lead    = lead_r;
    assign bus.trail   = trail_r;
endmodule
